// File: rtl/rv32i_mem_stage.sv
// RV32I memory-access stage: registers the EX/MEM boundary, runs byte/half/word
// loads and stores over a req/ack data port, and hands aligned results to writeback.
module rv32i_mem_stage #(
  parameter int unsigned WAIT_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        EX_Valid,
  input  logic [31:0] EX_ALU_result,
  input  logic [31:0] EX_Rs2_data,
  input  logic        EX_Mem_rd_en,
  input  logic        EX_Mem_wr_en,
  input  logic [2:0]  EX_Mem_op,
  input  logic        EX_RegFile_wr_en,
  input  logic        EX_MemToReg,
  input  logic [4:0]  EX_Rd_addr,
  output logic        Dmem_req,
  output logic        Dmem_we,
  output logic [31:0] Dmem_addr,
  output logic [31:0] Dmem_wdata,
  output logic [3:0]  Dmem_be,
  input  logic [31:0] Dmem_rdata,
  input  logic        Dmem_ack,
  output logic        MEM_Stall,
  output logic        MEM_Valid,
  output logic [31:0] MEM_ALU_result,
  output logic [31:0] MEM_Load_data,
  output logic        MEM_RegFile_wr_en,
  output logic        MEM_MemToReg,
  output logic [4:0]  MEM_Rd_addr,
  output logic        MEM_Fault
);

  localparam int unsigned CNT_W = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;

  localparam logic [2:0] OP_B  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_W  = 3'b010;
  localparam logic [2:0] OP_BU = 3'b100;
  localparam logic [2:0] OP_HU = 3'b101;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        lat_alu_q, lat_alu_d;
  logic [2:0]         lat_op_q, lat_op_d;
  logic [4:0]         lat_rd_q, lat_rd_d;
  logic               lat_rf_we_q, lat_rf_we_d;
  logic               lat_m2r_q, lat_m2r_d;
  logic               valid_q, valid_d;
  logic [31:0]        alu_q, alu_d;
  logic [31:0]        load_q, load_d;
  logic               rf_we_q, rf_we_d;
  logic               m2r_q, m2r_d;
  logic [4:0]         rd_q, rd_d;
  logic               fault_q, fault_d;

  logic               is_mem_c;
  logic               op_bad_c;
  logic               misalign_c;
  logic               timeout_c;

  // Select the addressed lane and extend it according to funct3.
  function automatic logic [31:0] load_extract(input logic [2:0] op,
                                               input logic [1:0] off,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    case (off)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = off[1] ? w[31:16] : w[15:0];
    case (op)
      OP_B:    load_extract = {{24{b[7]}}, b};
      OP_BU:   load_extract = {24'd0, b};
      OP_H:    load_extract = {{16{h[15]}}, h};
      OP_HU:   load_extract = {16'd0, h};
      OP_W:    load_extract = w;
      default: load_extract = 32'd0;
    endcase
  endfunction

  // Illegal-op and alignment screening of the incoming instruction.
  always_comb begin
    is_mem_c   = EX_Mem_rd_en | EX_Mem_wr_en;
    op_bad_c   = (EX_Mem_rd_en & EX_Mem_wr_en) ||
                 (EX_Mem_op == 3'b011) || (EX_Mem_op == 3'b110) || (EX_Mem_op == 3'b111) ||
                 (EX_Mem_wr_en & EX_Mem_op[2]);
    misalign_c = ((EX_Mem_op[1:0] == 2'b01) & EX_ALU_result[0]) ||
                 ((EX_Mem_op == OP_W) & (EX_ALU_result[1:0] != 2'b00));
    timeout_c  = (WAIT_TIMEOUT != 0) && (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    lat_alu_d   = lat_alu_q;
    lat_op_d    = lat_op_q;
    lat_rd_d    = lat_rd_q;
    lat_rf_we_d = lat_rf_we_q;
    lat_m2r_d   = lat_m2r_q;
    valid_d     = 1'b0;
    alu_d       = alu_q;
    load_d      = load_q;
    rf_we_d     = rf_we_q;
    m2r_d       = m2r_q;
    rd_d        = rd_q;
    fault_d     = fault_q;

    case (state_q)
      IDLE: begin
        if (EX_Valid) begin
          if (!is_mem_c || op_bad_c || misalign_c) begin
            valid_d = 1'b1;
            alu_d   = EX_ALU_result;
            rd_d    = EX_Rd_addr;
            m2r_d   = EX_MemToReg;
            load_d  = 32'd0;
            fault_d = is_mem_c;
            rf_we_d = is_mem_c ? 1'b0 : EX_RegFile_wr_en;
          end else begin
            state_d     = BUSY;
            cnt_d       = '0;
            req_d       = 1'b1;
            we_d        = EX_Mem_wr_en;
            addr_d      = {EX_ALU_result[31:2], 2'b00};
            lat_alu_d   = EX_ALU_result;
            lat_op_d    = EX_Mem_op;
            lat_rd_d    = EX_Rd_addr;
            lat_rf_we_d = EX_RegFile_wr_en;
            lat_m2r_d   = EX_MemToReg;
            wdata_d     = 32'd0;
            be_d        = 4'b1111;
            if (EX_Mem_wr_en) begin
              case (EX_Mem_op)
                OP_B: begin
                  wdata_d = {4{EX_Rs2_data[7:0]}};
                  be_d    = 4'b0001 << EX_ALU_result[1:0];
                end
                OP_H: begin
                  wdata_d = {2{EX_Rs2_data[15:0]}};
                  be_d    = EX_ALU_result[1] ? 4'b1100 : 4'b0011;
                end
                default: wdata_d = EX_Rs2_data;
              endcase
            end
          end
        end
      end
      BUSY: begin
        if (Dmem_ack || timeout_c) begin
          // Ack takes priority over a coincident timeout.
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          alu_d   = lat_alu_q;
          rd_d    = lat_rd_q;
          m2r_d   = lat_m2r_q;
          fault_d = !Dmem_ack;
          rf_we_d = Dmem_ack ? lat_rf_we_q : 1'b0;
          load_d  = (Dmem_ack && !we_q) ? load_extract(lat_op_q, lat_alu_q[1:0], Dmem_rdata)
                                        : 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      lat_alu_q   <= 32'd0;
      lat_op_q    <= 3'd0;
      lat_rd_q    <= 5'd0;
      lat_rf_we_q <= 1'b0;
      lat_m2r_q   <= 1'b0;
      valid_q     <= 1'b0;
      alu_q       <= 32'd0;
      load_q      <= 32'd0;
      rf_we_q     <= 1'b0;
      m2r_q       <= 1'b0;
      rd_q        <= 5'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      lat_alu_q   <= lat_alu_d;
      lat_op_q    <= lat_op_d;
      lat_rd_q    <= lat_rd_d;
      lat_rf_we_q <= lat_rf_we_d;
      lat_m2r_q   <= lat_m2r_d;
      valid_q     <= valid_d;
      alu_q       <= alu_d;
      load_q      <= load_d;
      rf_we_q     <= rf_we_d;
      m2r_q       <= m2r_d;
      rd_q        <= rd_d;
      fault_q     <= fault_d;
    end
  end

  assign MEM_Stall         = (state_q == BUSY);
  assign Dmem_req          = req_q;
  assign Dmem_we           = we_q;
  assign Dmem_addr         = addr_q;
  assign Dmem_wdata        = wdata_q;
  assign Dmem_be           = be_q;
  assign MEM_Valid         = valid_q;
  assign MEM_ALU_result    = alu_q;
  assign MEM_Load_data     = load_q;
  assign MEM_RegFile_wr_en = rf_we_q;
  assign MEM_MemToReg      = m2r_q;
  assign MEM_Rd_addr       = rd_q;
  assign MEM_Fault         = fault_q;

endmodule

// File: tb/tb_rv32i_mem_stage.sv
// Directed bench for rv32i_mem_stage with a short wait timeout; expected values hand-computed.
module tb_rv32i_mem_stage;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        EX_Valid;
  logic [31:0] EX_ALU_result;
  logic [31:0] EX_Rs2_data;
  logic        EX_Mem_rd_en;
  logic        EX_Mem_wr_en;
  logic [2:0]  EX_Mem_op;
  logic        EX_RegFile_wr_en;
  logic        EX_MemToReg;
  logic [4:0]  EX_Rd_addr;
  logic        Dmem_req;
  logic        Dmem_we;
  logic [31:0] Dmem_addr;
  logic [31:0] Dmem_wdata;
  logic [3:0]  Dmem_be;
  logic [31:0] Dmem_rdata;
  logic        Dmem_ack;
  logic        MEM_Stall;
  logic        MEM_Valid;
  logic [31:0] MEM_ALU_result;
  logic [31:0] MEM_Load_data;
  logic        MEM_RegFile_wr_en;
  logic        MEM_MemToReg;
  logic [4:0]  MEM_Rd_addr;
  logic        MEM_Fault;

  int n_checks = 0;
  int n_pass   = 0;
  int cycles;

  rv32i_mem_stage #(.WAIT_TIMEOUT(4)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .EX_Valid(EX_Valid), .EX_ALU_result(EX_ALU_result), .EX_Rs2_data(EX_Rs2_data),
    .EX_Mem_rd_en(EX_Mem_rd_en), .EX_Mem_wr_en(EX_Mem_wr_en), .EX_Mem_op(EX_Mem_op),
    .EX_RegFile_wr_en(EX_RegFile_wr_en), .EX_MemToReg(EX_MemToReg), .EX_Rd_addr(EX_Rd_addr),
    .Dmem_req(Dmem_req), .Dmem_we(Dmem_we), .Dmem_addr(Dmem_addr), .Dmem_wdata(Dmem_wdata),
    .Dmem_be(Dmem_be), .Dmem_rdata(Dmem_rdata), .Dmem_ack(Dmem_ack),
    .MEM_Stall(MEM_Stall), .MEM_Valid(MEM_Valid), .MEM_ALU_result(MEM_ALU_result),
    .MEM_Load_data(MEM_Load_data), .MEM_RegFile_wr_en(MEM_RegFile_wr_en),
    .MEM_MemToReg(MEM_MemToReg), .MEM_Rd_addr(MEM_Rd_addr), .MEM_Fault(MEM_Fault)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Present one instruction for a single capture edge, then drop EX_Valid.
  task automatic issue(input logic [31:0] addr, input logic [31:0] rs2, input logic rd_en,
                       input logic wr_en, input logic [2:0] op, input logic rf_we,
                       input logic m2r, input logic [4:0] rd);
    EX_Valid = 1'b1; EX_ALU_result = addr; EX_Rs2_data = rs2;
    EX_Mem_rd_en = rd_en; EX_Mem_wr_en = wr_en; EX_Mem_op = op;
    EX_RegFile_wr_en = rf_we; EX_MemToReg = m2r; EX_Rd_addr = rd;
    @(negedge Clk);
    EX_Valid = 1'b0; EX_Mem_rd_en = 1'b0; EX_Mem_wr_en = 1'b0;
  endtask

  // Count stall cycles, raising ack during the ack_at-th one (0 = never).
  task automatic run_busy(input int ack_at, output int n);
    n = 0;
    while (MEM_Stall && n < 20) begin
      check("req_held", 32'(Dmem_req), 32'd1);
      n++;
      if (n == ack_at) Dmem_ack = 1'b1;
      @(negedge Clk);
      Dmem_ack = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    Reset_n = 1'b0; EX_Valid = 1'b0; EX_ALU_result = '0; EX_Rs2_data = '0;
    EX_Mem_rd_en = 1'b0; EX_Mem_wr_en = 1'b0; EX_Mem_op = '0;
    EX_RegFile_wr_en = 1'b0; EX_MemToReg = 1'b0; EX_Rd_addr = '0;
    Dmem_rdata = '0; Dmem_ack = 1'b0;
    repeat (2) @(negedge Clk);
    check("rst_valid", 32'(MEM_Valid), 32'd0);
    check("rst_req",   32'(Dmem_req),  32'd0);
    check("rst_stall", 32'(MEM_Stall), 32'd0);
    check("rst_alu",   MEM_ALU_result, 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // ALU pass-through
    issue(32'h0000_1234, 32'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 5'd5);
    check("alu_valid", 32'(MEM_Valid), 32'd1);
    check("alu_res",   MEM_ALU_result, 32'h0000_1234);
    check("alu_rd",    32'(MEM_Rd_addr), 32'd5);
    check("alu_rfwe",  32'(MEM_RegFile_wr_en), 32'd1);
    check("alu_stall", 32'(MEM_Stall), 32'd0);
    check("alu_load",  MEM_Load_data, 32'd0);
    @(negedge Clk);
    check("alu_pulse", 32'(MEM_Valid), 32'd0);

    // LB / LBU at byte lane 3
    Dmem_rdata = 32'h80FF_0000;
    issue(32'h0000_0103, 32'd0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b1, 5'd7);
    check("lb_addr",  Dmem_addr, 32'h0000_0100);
    check("lb_we",    32'(Dmem_we), 32'd0);
    check("lb_be",    32'(Dmem_be), 32'hF);
    check("lb_valid0", 32'(MEM_Valid), 32'd0);
    run_busy(1, cycles);
    check("lb_stall_cycles", 32'(cycles), 32'd1);
    check("lb_valid", 32'(MEM_Valid), 32'd1);
    check("lb_data",  MEM_Load_data, 32'hFFFF_FF80);
    check("lb_rd",    32'(MEM_Rd_addr), 32'd7);
    check("lb_req_off", 32'(Dmem_req), 32'd0);
    issue(32'h0000_0103, 32'd0, 1'b1, 1'b0, 3'b100, 1'b1, 1'b1, 5'd7);
    run_busy(1, cycles);
    check("lbu_data", MEM_Load_data, 32'h0000_0080);

    // LH / LHU upper half
    Dmem_rdata = 32'h8001_1234;
    issue(32'h0000_0002, 32'd0, 1'b1, 1'b0, 3'b001, 1'b1, 1'b1, 5'd3);
    run_busy(1, cycles);
    check("lh_data", MEM_Load_data, 32'hFFFF_8001);
    issue(32'h0000_0002, 32'd0, 1'b1, 1'b0, 3'b101, 1'b1, 1'b1, 5'd3);
    run_busy(1, cycles);
    check("lhu_data", MEM_Load_data, 32'h0000_8001);

    // SH at upper half, ack on third busy cycle
    issue(32'h0000_0202, 32'hDEAD_BEEF, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0, 5'd0);
    check("sh_we",    32'(Dmem_we), 32'd1);
    check("sh_be",    32'(Dmem_be), 32'hC);
    check("sh_wdata", Dmem_wdata, 32'hBEEF_BEEF);
    check("sh_addr",  Dmem_addr, 32'h0000_0200);
    run_busy(3, cycles);
    check("sh_stall_cycles", 32'(cycles), 32'd3);
    check("sh_valid", 32'(MEM_Valid), 32'd1);
    check("sh_fault", 32'(MEM_Fault), 32'd0);

    // SB at lane 1
    issue(32'h0000_0001, 32'h0000_00AB, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd0);
    check("sb_be",    32'(Dmem_be), 32'h2);
    check("sb_wdata", Dmem_wdata, 32'hABAB_ABAB);
    run_busy(1, cycles);

    // Ack while idle is ignored
    Dmem_ack = 1'b1;
    @(negedge Clk);
    Dmem_ack = 1'b0;
    check("idle_ack_valid", 32'(MEM_Valid), 32'd0);
    check("idle_ack_stall", 32'(MEM_Stall), 32'd0);

    // Faults: misaligned LW, op 011, store with op 100, both enables
    issue(32'h0000_0301, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd9);
    check("lw_mis_req",   32'(Dmem_req), 32'd0);
    check("lw_mis_valid", 32'(MEM_Valid), 32'd1);
    check("lw_mis_fault", 32'(MEM_Fault), 32'd1);
    check("lw_mis_rfwe",  32'(MEM_RegFile_wr_en), 32'd0);
    issue(32'h0000_0300, 32'd0, 1'b1, 1'b0, 3'b011, 1'b1, 1'b1, 5'd9);
    check("op011_req",   32'(Dmem_req), 32'd0);
    check("op011_fault", 32'(MEM_Fault), 32'd1);
    check("op011_rfwe",  32'(MEM_RegFile_wr_en), 32'd0);
    issue(32'h0000_0300, 32'd0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b0, 5'd0);
    check("sbu_fault", 32'(MEM_Fault), 32'd1);
    check("sbu_req",   32'(Dmem_req), 32'd0);
    issue(32'h0000_0300, 32'd0, 1'b1, 1'b1, 3'b010, 1'b1, 1'b0, 5'd1);
    check("rdwr_fault", 32'(MEM_Fault), 32'd1);

    // Timeout after four busy cycles, then a normal ALU op
    issue(32'h0000_0400, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd4);
    run_busy(0, cycles);
    check("to_cycles", 32'(cycles), 32'd4);
    check("to_req",    32'(Dmem_req), 32'd0);
    check("to_valid",  32'(MEM_Valid), 32'd1);
    check("to_fault",  32'(MEM_Fault), 32'd1);
    check("to_rfwe",   32'(MEM_RegFile_wr_en), 32'd0);
    issue(32'h0000_00AA, 32'd0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 5'd6);
    check("post_to_valid", 32'(MEM_Valid), 32'd1);
    check("post_to_fault", 32'(MEM_Fault), 32'd0);
    check("post_to_alu",   MEM_ALU_result, 32'h0000_00AA);

    // Ack coinciding with the timeout cycle completes normally
    Dmem_rdata = 32'hCAFE_F00D;
    issue(32'h0000_0404, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd8);
    run_busy(4, cycles);
    check("race_cycles", 32'(cycles), 32'd4);
    check("race_fault",  32'(MEM_Fault), 32'd0);
    check("race_data",   MEM_Load_data, 32'hCAFE_F00D);
    check("race_rfwe",   32'(MEM_RegFile_wr_en), 32'd1);

    // Asynchronous reset mid-access
    issue(32'h0000_0500, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd2);
    check("pre_rst_req", 32'(Dmem_req), 32'd1);
    #2 Reset_n = 1'b0;
    #1;
    check("arst_req",   32'(Dmem_req), 32'd0);
    check("arst_stall", 32'(MEM_Stall), 32'd0);
    check("arst_alu",   MEM_ALU_result, 32'd0);
    check("arst_load",  MEM_Load_data, 32'd0);
    check("arst_rd",    32'(MEM_Rd_addr), 32'd0);
    check("arst_rfwe",  32'(MEM_RegFile_wr_en), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
    Dmem_rdata = 32'h1234_5678;
    issue(32'h0000_0600, 32'd0, 1'b1, 1'b0, 3'b010, 1'b1, 1'b1, 5'd10);
    check("post_rst_addr", Dmem_addr, 32'h0000_0600);
    run_busy(1, cycles);
    check("post_rst_data",  MEM_Load_data, 32'h1234_5678);
    check("post_rst_fault", 32'(MEM_Fault), 32'd0);
    check("post_rst_rd",    32'(MEM_Rd_addr), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
